// File: rtl/ps2_scroll_display.sv
// rtl/ps2_scroll_display.sv - PS/2 scan-code line buffer with scrolling seven-segment multiplexer
module ps2_scroll_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int BUF_DEPTH   = 8,
  parameter int REFRESH_DIV = 65536
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_code_valid,
  input  logic [7:0]                         i_code,
  output logic [NUM_DIGITS-1:0]              o_digit_sel,
  output logic [7:0]                         o_segments,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     o_count
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } dec_state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_INSERT,
    ACT_BACKSPACE,
    ACT_CLEAR,
    ACT_LEFT,
    ACT_RIGHT
  } act_t;

  // Returns {hit, active-low glyph} for every scan code that types a character.
  function automatic logic [8:0] lookup_glyph(input logic [7:0] code);
    logic [8:0] r;
    r = {1'b0, 8'hFF};
    case (code)
      8'h45: r = {1'b1, 8'hC0};
      8'h16: r = {1'b1, 8'hF9};
      8'h1E: r = {1'b1, 8'hA4};
      8'h26: r = {1'b1, 8'hB0};
      8'h25: r = {1'b1, 8'h99};
      8'h2E: r = {1'b1, 8'h92};
      8'h36: r = {1'b1, 8'h82};
      8'h3D: r = {1'b1, 8'hF8};
      8'h3E: r = {1'b1, 8'h80};
      8'h46: r = {1'b1, 8'h90};
      8'h1C: r = {1'b1, 8'h88};
      8'h32: r = {1'b1, 8'h83};
      8'h21: r = {1'b1, 8'hC6};
      8'h23: r = {1'b1, 8'hA1};
      8'h24: r = {1'b1, 8'h86};
      8'h2B: r = {1'b1, 8'h8E};
      8'h33: r = {1'b1, 8'h89};
      8'h43: r = {1'b1, 8'hCF};
      8'h4B: r = {1'b1, 8'hC7};
      8'h31: r = {1'b1, 8'hAB};
      8'h44: r = {1'b1, 8'hA3};
      8'h4D: r = {1'b1, 8'h8C};
      8'h15: r = {1'b1, 8'h98};
      8'h2D: r = {1'b1, 8'hAF};
      8'h1B: r = {1'b1, 8'h92};
      8'h2C: r = {1'b1, 8'h87};
      8'h3C: r = {1'b1, 8'hC1};
      8'h29: r = {1'b1, 8'hFF};
      8'h4E: r = {1'b1, 8'hBF};
      8'h49: r = {1'b1, 8'h7F};
      default: r = {1'b0, 8'hFF};
    endcase
    return r;
  endfunction

  dec_state_t     state_q, state_d;
  act_t           act_q, act_d;
  logic [7:0]     glyph_q, glyph_d;
  logic [8:0]     glyph_hit;

  logic [7:0]     buf_q [BUF_DEPTH];
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  offset_q;
  logic [CW-1:0]  max_offset;

  logic [PW-1:0]  presc_q;
  logic [DW-1:0]  idx_q;
  logic [DW-1:0]  idx_next;
  logic           presc_wrap;
  logic [CW-1:0]  entry_sel;
  logic [7:0]     seg_next;

  assign glyph_hit = lookup_glyph(i_code);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = ACT_NONE;
    glyph_d = 8'hFF;
    if (i_code_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (i_code == 8'hF0) begin
            state_d = ST_BRK;
          end else if (i_code == 8'hE0) begin
            state_d = ST_EXT;
          end else if (glyph_hit[8]) begin
            act_d   = ACT_INSERT;
            glyph_d = glyph_hit[7:0];
          end else if (i_code == 8'h66) begin
            act_d = ACT_BACKSPACE;
          end else if (i_code == 8'h5A) begin
            act_d = ACT_CLEAR;
          end
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          if (i_code == 8'hF0) begin
            state_d = ST_EXT_BRK;
          end else if (i_code == 8'h6B) begin
            act_d = ACT_LEFT;
          end else if (i_code == 8'h74) begin
            act_d = ACT_RIGHT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Decoded action is staged one cycle so the buffer updates on the edge after acceptance.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      act_q   <= ACT_NONE;
      glyph_q <= 8'hFF;
    end else begin
      act_q   <= act_d;
      glyph_q <= glyph_d;
    end
  end

  assign max_offset = (count_q > CW'(NUM_DIGITS)) ? count_q - CW'(NUM_DIGITS) : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int e = 0; e < BUF_DEPTH; e++) buf_q[e] <= 8'hFF;
      count_q  <= '0;
      offset_q <= '0;
    end else begin
      case (act_q)
        ACT_INSERT: begin
          buf_q[0] <= glyph_q;
          for (int e = 1; e < BUF_DEPTH; e++) buf_q[e] <= buf_q[e-1];
          if (count_q != CW'(BUF_DEPTH)) count_q <= count_q + 1'b1;
          offset_q <= '0;
        end
        ACT_BACKSPACE: begin
          if (count_q != '0) begin
            for (int e = 0; e < BUF_DEPTH - 1; e++) buf_q[e] <= buf_q[e+1];
            buf_q[BUF_DEPTH-1] <= 8'hFF;
            count_q  <= count_q - 1'b1;
            offset_q <= '0;
          end
        end
        ACT_CLEAR: begin
          for (int e = 0; e < BUF_DEPTH; e++) buf_q[e] <= 8'hFF;
          count_q  <= '0;
          offset_q <= '0;
        end
        ACT_LEFT: begin
          if (offset_q < max_offset) offset_q <= offset_q + 1'b1;
        end
        ACT_RIGHT: begin
          if (offset_q != '0) offset_q <= offset_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_count    = count_q;
  assign presc_wrap = (presc_q == PW'(REFRESH_DIV - 1));
  assign idx_next   = (idx_q == DW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
  assign entry_sel  = offset_q + CW'(idx_next);

  // Glyph for the digit about to be enabled, so select and segments switch together.
  always_comb begin
    seg_next = 8'hFF;
    for (int e = 0; e < BUF_DEPTH; e++) begin
      if (entry_sel == CW'(e) && entry_sel < count_q) seg_next = buf_q[e];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc_q     <= '0;
      idx_q       <= '0;
      o_digit_sel <= ~NUM_DIGITS'(1);
      o_segments  <= 8'hFF;
    end else if (presc_wrap) begin
      presc_q     <= '0;
      idx_q       <= idx_next;
      o_digit_sel <= ~(NUM_DIGITS'(1) << idx_next);
      o_segments  <= seg_next;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

endmodule
